// File: rtl/y86_execute_mc.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// y86_execute_mc
// Y86 execute stage with a multi-cycle shift-add multiplier, CC register,
// cmov/jXX condition evaluation, forwarding outputs and the E->M register.
//
// Ports
//   clk, rst_n          : rising-edge clock, synchronous active-low reset
//   E_stat/E_icode/...  : instruction currently in the E stage
//   m_stat, W_stat      : stats of the instructions in M and W (gate CC)
//   M_stall, M_bubble   : hold / bubble control for the M register
//   e_valE/e_dstE/e_cnd : combinational execute results for forwarding
//   e_busy              : multiply in progress, upstream must hold E
//   M_*                 : registered M pipeline register contents
// ---------------------------------------------------------------------------
module y86_execute_mc #(
  parameter int DATA_W   = 64,
  parameter int STK_STEP = DATA_W / 8,
  parameter int CNT_W    = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic [1:0]        m_stat,
  input  logic [1:0]        W_stat,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic [DATA_W-1:0] e_valE,
  output logic [3:0]        e_dstE,
  output logic              e_cnd,
  output logic              e_busy,
  output logic [3:0]        M_icode,
  output logic [1:0]        M_stat,
  output logic              M_cnd,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA
);

  localparam int MSB = DATA_W - 1;
  localparam logic [1:0] STAT_AOK = 2'b01;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] ALU_MUL = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [DATA_W-1:0] STEP      = DATA_W'(STK_STEP);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} mulState_e;

  mulState_e         state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        cc_q, cc_d;

  logic [3:0]        mIcode_q, mIcode_d, mDstE_q, mDstE_d, mDstM_q, mDstM_d;
  logic [1:0]        mStat_q, mStat_d;
  logic              mCnd_q, mCnd_d;
  logic [DATA_W-1:0] mValE_q, mValE_d, mValA_q, mValA_d;

  logic              mulStart, aluOf, ccWrite, ccOf, ccSf, ccZf, lessThan;
  logic [DATA_W-1:0] aluOut, sumBA, diffBA;

  assign sumBA    = E_valB + E_valA;
  assign diffBA   = E_valB - E_valA;
  assign mulStart = (E_icode == I_OPQ) && (E_ifun == ALU_MUL) && (E_stat == STAT_AOK);

  // Multiply sequencer. The multiplicand shifts left and the multiplier
  // shifts right so each RUN cycle only needs one conditional add; after
  // DATA_W steps the accumulator holds the low DATA_W bits of the product,
  // which is also the two's-complement result. DONE waits for M to take it.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    e_busy   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mulStart) begin
          state_d  = RUN;
          mcand_d  = E_valB;
          mplier_d = E_valA;
          acc_d    = '0;
          cnt_d    = '0;
          e_busy   = 1'b1;
        end
      end
      RUN: begin
        e_busy   = 1'b1;
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!M_stall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU: operand selection by icode plus the OPq function. Overflow is
  // derived from operand/result sign bits; the multiply result only shows
  // up once the sequencer reaches DONE, otherwise a mul reads as zero.
  always_comb begin
    aluOut = '0;
    aluOf  = 1'b0;
    case (E_icode)
      I_RRMOV:          aluOut = E_valA;
      I_IRMOV:          aluOut = E_valC;
      I_RMMOV, I_MRMOV: aluOut = E_valB + E_valC;
      I_OPQ: begin
        case (E_ifun)
          4'h0: begin
            aluOut = sumBA;
            aluOf  = (E_valA[MSB] == E_valB[MSB]) && (sumBA[MSB] != E_valB[MSB]);
          end
          4'h1: begin
            aluOut = diffBA;
            aluOf  = (E_valA[MSB] != E_valB[MSB]) && (diffBA[MSB] != E_valB[MSB]);
          end
          4'h2:    aluOut = E_valB & E_valA;
          4'h3:    aluOut = E_valB ^ E_valA;
          ALU_MUL: aluOut = (state_q == DONE) ? acc_q : '0;
          default: aluOut = '0;
        endcase
      end
      I_CALL, I_PUSH:   aluOut = E_valB - STEP;
      I_RET, I_POP:     aluOut = E_valB + STEP;
      default:          aluOut = '0;
    endcase
  end

  assign e_valE = aluOut;

  // Condition evaluation from the stored flags; only cmov and jXX look at
  // the flags, every other instruction is treated as unconditional.
  assign {ccOf, ccSf, ccZf} = cc_q;
  assign lessThan = ccSf ^ ccOf;

  always_comb begin
    e_cnd = 1'b1;
    if ((E_icode == I_RRMOV) || (E_icode == I_JXX)) begin
      case (E_ifun)
        4'h0:    e_cnd = 1'b1;
        4'h1:    e_cnd = lessThan | ccZf;
        4'h2:    e_cnd = lessThan;
        4'h3:    e_cnd = ccZf;
        4'h4:    e_cnd = ~ccZf;
        4'h5:    e_cnd = ~lessThan;
        4'h6:    e_cnd = ~lessThan & ~ccZf;
        default: e_cnd = 1'b0;
      endcase
    end
  end

  assign e_dstE = e_cnd ? E_dstE : REG_NONE;

  // Flags update only for a valid OPq that is actually leaving E this cycle
  // while nothing older in the pipe has faulted or halted.
  assign ccWrite = (E_icode == I_OPQ) && (E_ifun <= ALU_MUL) &&
                   (E_stat == STAT_AOK) && (m_stat == STAT_AOK) &&
                   (W_stat == STAT_AOK) && !M_stall && !e_busy;
  assign cc_d = ccWrite ? {aluOf, aluOut[MSB], (aluOut == '0)} : cc_q;

  // M register next state: bubble beats stall, and a busy multiply feeds
  // bubbles into M until its result is ready.
  always_comb begin
    mIcode_d = mIcode_q;
    mStat_d  = mStat_q;
    mCnd_d   = mCnd_q;
    mDstE_d  = mDstE_q;
    mDstM_d  = mDstM_q;
    mValE_d  = mValE_q;
    mValA_d  = mValA_q;
    if (M_bubble || (!M_stall && e_busy)) begin
      mIcode_d = I_NOP;
      mStat_d  = STAT_AOK;
      mCnd_d   = 1'b0;
      mDstE_d  = REG_NONE;
      mDstM_d  = REG_NONE;
      mValE_d  = '0;
      mValA_d  = '0;
    end else if (!M_stall) begin
      mIcode_d = E_icode;
      mStat_d  = E_stat;
      mCnd_d   = e_cnd;
      mDstE_d  = e_dstE;
      mDstM_d  = E_dstM;
      mValE_d  = e_valE;
      mValA_d  = E_valA;
    end
  end

  // State registers with synchronous reset; reset also abandons any
  // multiply in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      cc_q     <= 3'b001;
      mIcode_q <= I_NOP;
      mStat_q  <= STAT_AOK;
      mCnd_q   <= 1'b0;
      mDstE_q  <= REG_NONE;
      mDstM_q  <= REG_NONE;
      mValE_q  <= '0;
      mValA_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      cc_q     <= cc_d;
      mIcode_q <= mIcode_d;
      mStat_q  <= mStat_d;
      mCnd_q   <= mCnd_d;
      mDstE_q  <= mDstE_d;
      mDstM_q  <= mDstM_d;
      mValE_q  <= mValE_d;
      mValA_q  <= mValA_d;
    end
  end

  assign M_icode = mIcode_q;
  assign M_stat  = mStat_q;
  assign M_cnd   = mCnd_q;
  assign M_dstE  = mDstE_q;
  assign M_dstM  = mDstM_q;
  assign M_valE  = mValE_q;
  assign M_valA  = mValA_q;

endmodule

// File: tb/tb_y86_execute_mc.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_y86_execute_mc
// Drives directed Y86 instructions into a 64-bit execute stage and a 32-bit
// copy (stack step 4). A cycle-level reference model of the stage runs
// alongside the 64-bit copy and is compared against it on every falling edge.
// ---------------------------------------------------------------------------
module tb_y86_execute_mc;

  localparam int W = 64;
  localparam logic [1:0] AOK = 2'b01;
  localparam logic [1:0] HLT = 2'b10;
  localparam logic [1:0] ADR = 2'b11;
  typedef logic [W-1:0] word_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  eStat, mStatIn, wStatIn;
  logic [3:0]  eIcode, eIfun, eDstE, eDstM;
  word_t       eValA, eValB, eValC;
  logic        mStall, mBubble;

  word_t       eValEOut, mValEOut, mValAOut;
  logic [3:0]  eDstEOut, mIcodeOut, mDstEOut, mDstMOut;
  logic        eCndOut, eBusyOut, mCndOut;
  logic [1:0]  mStatOut;

  logic [3:0]  sIcode;
  logic [31:0] sValB;
  logic [31:0] sEValE, sMValE, sMValA;
  logic [3:0]  sEDstE, sMIcode, sMDstE, sMDstM;
  logic        sECnd, sEBusy, sMCnd;
  logic [1:0]  sMStat;

  int checks   = 0;
  int failures = 0;

  // Reference model state: CC flags {OF,SF,ZF}, the M register and the
  // multiply in flight tracked by its age in cycles.
  bit          modelValid = 1'b0;
  logic [2:0]  modelCc;
  logic [3:0]  modelIcode, modelDstE, modelDstM;
  logic [1:0]  modelStat;
  logic        modelCnd;
  word_t       modelValE, modelValA;
  bit          mulActive;
  int          mulAge;
  word_t       mulProd;

  always #5 clk = ~clk;

  y86_execute_mc #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rstN),
    .E_stat(eStat), .E_icode(eIcode), .E_ifun(eIfun),
    .E_valA(eValA), .E_valB(eValB), .E_valC(eValC),
    .E_dstE(eDstE), .E_dstM(eDstM),
    .m_stat(mStatIn), .W_stat(wStatIn),
    .M_stall(mStall), .M_bubble(mBubble),
    .e_valE(eValEOut), .e_dstE(eDstEOut), .e_cnd(eCndOut), .e_busy(eBusyOut),
    .M_icode(mIcodeOut), .M_stat(mStatOut), .M_cnd(mCndOut),
    .M_dstE(mDstEOut), .M_dstM(mDstMOut), .M_valE(mValEOut), .M_valA(mValAOut)
  );

  y86_execute_mc #(.DATA_W(32)) dut32 (
    .clk(clk), .rst_n(rstN),
    .E_stat(AOK), .E_icode(sIcode), .E_ifun(4'h0),
    .E_valA(32'h0000_0011), .E_valB(sValB), .E_valC(32'h0),
    .E_dstE(4'h4), .E_dstM(4'hF),
    .m_stat(AOK), .W_stat(AOK),
    .M_stall(1'b0), .M_bubble(1'b0),
    .e_valE(sEValE), .e_dstE(sEDstE), .e_cnd(sECnd), .e_busy(sEBusy),
    .M_icode(sMIcode), .M_stat(sMStat), .M_cnd(sMCnd),
    .M_dstE(sMDstE), .M_dstM(sMDstM), .M_valE(sMValE), .M_valA(sMValA)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference behaviour of the combinational outputs: overflow is taken
  // from a one-bit-wider signed sum, conditions from signed-less-than.
  task automatic modelComb(output word_t v, output logic [2:0] flags, output logic cnd,
                           output logic [3:0] dst, output logic busy);
    logic signed [W:0] wide;
    logic of, lt;
    busy = (!mulActive && eIcode == 4'h6 && eIfun == 4'h4 && eStat == AOK) ||
           (mulActive && mulAge <= W);
    v  = '0;
    of = 1'b0;
    case (eIcode)
      4'h2: v = eValA;
      4'h3: v = eValC;
      4'h4, 4'h5: v = eValB + eValC;
      4'h6: begin
        case (eIfun)
          4'h0: begin
            wide = $signed({eValB[W-1], eValB}) + $signed({eValA[W-1], eValA});
            v = wide[W-1:0];
            of = wide[W] ^ wide[W-1];
          end
          4'h1: begin
            wide = $signed({eValB[W-1], eValB}) - $signed({eValA[W-1], eValA});
            v = wide[W-1:0];
            of = wide[W] ^ wide[W-1];
          end
          4'h2: v = eValB & eValA;
          4'h3: v = eValB ^ eValA;
          4'h4: v = (mulActive && mulAge > W) ? mulProd : '0;
          default: v = '0;
        endcase
      end
      4'h8, 4'hA: v = eValB - 64'd8;
      4'h9, 4'hB: v = eValB + 64'd8;
      default: v = '0;
    endcase
    flags = {of, v[W-1], (v == '0)};
    lt  = modelCc[2] != modelCc[1];
    cnd = 1'b1;
    if (eIcode == 4'h2 || eIcode == 4'h7) begin
      case (eIfun)
        4'h0: cnd = 1'b1;
        4'h1: cnd = lt || modelCc[0];
        4'h2: cnd = lt;
        4'h3: cnd = modelCc[0];
        4'h4: cnd = !modelCc[0];
        4'h5: cnd = !lt;
        4'h6: cnd = !lt && !modelCc[0];
        default: cnd = 1'b0;
      endcase
    end
    dst = cnd ? eDstE : 4'hF;
  endtask

  // Model state advance at each rising edge.
  initial begin : modelProc
    word_t v;
    logic [2:0] f;
    logic c, b;
    logic [3:0] d;
    forever begin
      @(posedge clk);
      if (!rstN) begin
        modelCc = 3'b001; modelIcode = 4'h1; modelStat = AOK; modelCnd = 1'b0;
        modelDstE = 4'hF; modelDstM = 4'hF; modelValE = '0; modelValA = '0;
        mulActive = 1'b0; mulAge = 0; mulProd = '0;
        modelValid = 1'b1;
      end else begin
        modelComb(v, f, c, d, b);
        if (eIcode == 4'h6 && eIfun <= 4'h4 && eStat == AOK && mStatIn == AOK &&
            wStatIn == AOK && !mStall && !b)
          modelCc = f;
        if (mBubble || (!mStall && b)) begin
          modelIcode = 4'h1; modelStat = AOK; modelCnd = 1'b0;
          modelDstE = 4'hF; modelDstM = 4'hF; modelValE = '0; modelValA = '0;
        end else if (!mStall) begin
          modelIcode = eIcode; modelStat = eStat; modelCnd = c;
          modelDstE = d; modelDstM = eDstM; modelValE = v; modelValA = eValA;
        end
        if (!mulActive) begin
          if (eIcode == 4'h6 && eIfun == 4'h4 && eStat == AOK) begin
            mulActive = 1'b1; mulAge = 1; mulProd = eValA * eValB;
          end
        end else if (mulAge <= W) begin
          mulAge++;
        end else if (!mStall) begin
          mulActive = 1'b0;
        end
      end
    end
  end

  // Every falling edge: DUT outputs against the model.
  initial begin : cmpProc
    word_t v;
    logic [2:0] f;
    logic c, b;
    logic [3:0] d;
    forever begin
      @(negedge clk);
      if (modelValid) begin
        modelComb(v, f, c, d, b);
        checkOutput("cyc e_valE", eValEOut, v);
        checkOutput("cyc e_cnd", 64'(eCndOut), 64'(c));
        checkOutput("cyc e_dstE", 64'(eDstEOut), 64'(d));
        checkOutput("cyc e_busy", 64'(eBusyOut), 64'(b));
        checkOutput("cyc M_icode", 64'(mIcodeOut), 64'(modelIcode));
        checkOutput("cyc M_stat", 64'(mStatOut), 64'(modelStat));
        checkOutput("cyc M_cnd", 64'(mCndOut), 64'(modelCnd));
        checkOutput("cyc M_dstE", 64'(mDstEOut), 64'(modelDstE));
        checkOutput("cyc M_dstM", 64'(mDstMOut), 64'(modelDstM));
        checkOutput("cyc M_valE", mValEOut, modelValE);
        checkOutput("cyc M_valA", mValAOut, modelValA);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                               input word_t valA, input word_t valB, input word_t valC,
                               input logic [3:0] dstE, input logic [1:0] mst,
                               input logic stall, input logic bubble);
    @(posedge clk); #1;
    eStat = stat; eIcode = icode; eIfun = ifun;
    eValA = valA; eValB = valB; eValC = valC;
    eDstE = dstE; eDstM = 4'hA;
    mStatIn = mst; wStatIn = AOK; mStall = stall; mBubble = bubble;
    @(negedge clk);
  endtask

  task automatic op(input logic [3:0] icode, input logic [3:0] ifun, input word_t valA,
                    input word_t valB, input word_t valC, input logic [3:0] dstE);
    applyStimulus(AOK, icode, ifun, valA, valB, valC, dstE, AOK, 1'b0, 1'b0);
  endtask

  initial begin : watchdog
    #100000;
    failures++;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    int busyCycles;
    rstN = 1'b0;
    eStat = AOK; eIcode = 4'h1; eIfun = 4'h0; eValA = '0; eValB = '0; eValC = '0;
    eDstE = 4'hF; eDstM = 4'hF; mStatIn = AOK; wStatIn = AOK; mStall = 1'b0; mBubble = 1'b0;
    sIcode = 4'h1; sValB = 32'h0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkOutput("reset M_icode", 64'(mIcodeOut), 64'h1);
    checkOutput("reset M_dstE", 64'(mDstEOut), 64'hF);
    checkOutput("reset e_busy", 64'(eBusyOut), 64'h0);

    op(4'h2, 4'h1, 64'h55, 64'h0, 64'h0, 4'h3);                     // cmovle, CC=001
    checkOutput("cmovle e_cnd", 64'(eCndOut), 64'h1);
    checkOutput("cmovle e_dstE", 64'(eDstEOut), 64'h3);
    checkOutput("cmovle e_valE", eValEOut, 64'h55);
    op(4'h2, 4'h6, 64'h66, 64'h0, 64'h0, 4'h4);                     // cmovg
    checkOutput("cmovg e_cnd", 64'(eCndOut), 64'h0);
    checkOutput("cmovg e_dstE", 64'(eDstEOut), 64'hF);
    op(4'h6, 4'h0, 64'd7, 64'd5, 64'h0, 4'h2);                      // addq
    checkOutput("addq e_valE", eValEOut, 64'd12);
    checkOutput("cmovg M_dstE", 64'(mDstEOut), 64'hF);
    op(4'h2, 4'h3, 64'h1, 64'h0, 64'h0, 4'h5);                      // cmove
    checkOutput("addq ZF clear", 64'(eCndOut), 64'h0);
    checkOutput("addq M_valE", mValEOut, 64'd12);
    checkOutput("addq M_icode", 64'(mIcodeOut), 64'h6);
    op(4'h2, 4'h4, 64'h1, 64'h0, 64'h0, 4'h5);                      // cmovne
    checkOutput("cmovne e_cnd", 64'(eCndOut), 64'h1);
    op(4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h2);    // addq overflow
    checkOutput("addq ovf e_valE", eValEOut, 64'h8000_0000_0000_0000);
    op(4'h2, 4'h2, 64'h1, 64'h0, 64'h0, 4'h5);                      // cmovl: SF^OF=0
    checkOutput("ovf cmovl", 64'(eCndOut), 64'h0);
    op(4'h6, 4'h1, 64'd5, 64'd5, 64'h0, 4'h2);                      // subq -> 0
    checkOutput("subq e_valE", eValEOut, 64'h0);
    op(4'h7, 4'h3, 64'h0, 64'h0, 64'h40, 4'hF);                     // je
    checkOutput("subq je", 64'(eCndOut), 64'h1);
    applyStimulus(AOK, 4'h6, 4'h1, 64'd1, 64'd5, 64'h0, 4'h2, HLT, 1'b0, 1'b0);
    checkOutput("subq gated e_valE", eValEOut, 64'd4);
    op(4'h7, 4'h3, 64'h0, 64'h0, 64'h40, 4'hF);                     // je, CC untouched
    checkOutput("gated je", 64'(eCndOut), 64'h1);
    op(4'h3, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h5);                   // irmovq
    checkOutput("irmovq e_valE", eValEOut, 64'h1234);
    applyStimulus(AOK, 4'h5, 4'h0, 64'h0, 64'h100, 64'h20, 4'hF, AOK, 1'b1, 1'b0);
    checkOutput("mrmovq e_valE", eValEOut, 64'h120);
    applyStimulus(AOK, 4'h6, 4'h0, 64'd2, 64'd3, 64'h0, 4'h6, AOK, 1'b0, 1'b1);
    checkOutput("stall M_valE", mValEOut, 64'h1234);
    checkOutput("stall M_icode", 64'(mIcodeOut), 64'h3);
    op(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
    checkOutput("bubble M_icode", 64'(mIcodeOut), 64'h1);
    checkOutput("bubble M_valE", mValEOut, 64'h0);

    // Multiply 6 * -7, with a short M_bubble pulse while it runs.
    op(4'h6, 4'h4, 64'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 4'h7);
    busyCycles = 0;
    while (eBusyOut && busyCycles < 200) begin
      busyCycles++;
      if (busyCycles > 1) checkOutput("mul M_icode nop", 64'(mIcodeOut), 64'h1);
      @(posedge clk); #1;
      mBubble = (busyCycles == 10) || (busyCycles == 11);
      @(negedge clk);
    end
    checkOutput("mul busy cycles", 64'(busyCycles), 64'd65);
    checkOutput("mul e_valE", eValEOut, 64'hFFFF_FFFF_FFFF_FFD6);
    op(4'h2, 4'h2, 64'h1, 64'h0, 64'h0, 4'h5);                      // cmovl: SF=1
    checkOutput("mul cmovl", 64'(eCndOut), 64'h1);
    checkOutput("mul M_valE", mValEOut, 64'hFFFF_FFFF_FFFF_FFD6);
    checkOutput("mul M_icode", 64'(mIcodeOut), 64'h6);
    op(4'h2, 4'h3, 64'h1, 64'h0, 64'h0, 4'h5);                      // cmove: ZF=0
    checkOutput("mul cmove", 64'(eCndOut), 64'h0);
    applyStimulus(ADR, 4'h6, 4'h4, 64'd3, 64'd4, 64'h0, 4'h7, AOK, 1'b0, 1'b0);
    checkOutput("bad mul busy", 64'(eBusyOut), 64'h0);
    checkOutput("bad mul e_valE", eValEOut, 64'h0);
    op(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);

    // 32-bit instance: stack pointer steps of 4.
    @(posedge clk); #1; sIcode = 4'hA; sValB = 32'h100;
    @(negedge clk);
    checkOutput("push32 e_valE", 64'(sEValE), 64'hFC);
    checkOutput("push32 e_busy", 64'(sEBusy), 64'h0);
    @(posedge clk); #1; sIcode = 4'hB;
    @(negedge clk);
    checkOutput("pop32 e_valE", 64'(sEValE), 64'h104);
    checkOutput("push32 M_valE", 64'(sMValE), 64'hFC);
    checkOutput("push32 M_icode", 64'(sMIcode), 64'hA);
    @(posedge clk); #1; sIcode = 4'h8;
    @(negedge clk);
    checkOutput("call32 e_valE", 64'(sEValE), 64'hFC);
    checkOutput("pop32 M_valE", 64'(sMValE), 64'h104);
    checkOutput("pop32 M_misc", {48'h0, sMStat, sMCnd, sEDstE, sMDstE, sMDstM, sECnd},
                {48'h0, 2'b01, 1'b1, 4'h4, 4'h4, 4'hF, 1'b1});
    checkOutput("pop32 M_valA", 64'(sMValA), 64'h11);
    @(posedge clk); #1; sIcode = 4'h1;

    // Reset in the middle of a multiply.
    op(4'h6, 4'h4, 64'd3, 64'd9, 64'h0, 4'h9);
    repeat (20) @(posedge clk);
    #1;
    rstN = 1'b0;
    eStat = AOK; eIcode = 4'h1; eIfun = 4'h0; eValA = '0; eValB = '0; eDstE = 4'hF;
    @(negedge clk);
    checkOutput("pre-reset busy", 64'(eBusyOut), 64'h1);
    @(posedge clk); #1;
    rstN = 1'b1;
    eIcode = 4'h2; eIfun = 4'h3; eValA = 64'h77; eDstE = 4'h6;
    @(negedge clk);
    checkOutput("rst e_busy", 64'(eBusyOut), 64'h0);
    checkOutput("rst M_icode", 64'(mIcodeOut), 64'h1);
    checkOutput("rst M_valE", mValEOut, 64'h0);
    checkOutput("rst cmove ZF", 64'(eCndOut), 64'h1);
    checkOutput("rst cmove e_dstE", 64'(eDstEOut), 64'h6);
    op(4'h2, 4'h2, 64'h1, 64'h0, 64'h0, 4'h5);
    checkOutput("rst cmovl", 64'(eCndOut), 64'h0);
    op(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/y86_execute_mc.md
Name: y86_execute_mc

Overview:
- Parametrised Y86 execute stage with E->M pipeline register, condition-code (CC) register, cmov/jXX condition evaluation and forwarding outputs.
- Adds a multi-cycle iterative multiply (OPq ifun 4), with a busy/stall request to upstream.
- Adds explicit M-register stall/bubble control and a configurable stack step.
- Sits between the decode (E) and memory (M) pipeline registers.

Parameters:
DATA_W, 64, datapath width; must be >= 8 and a multiple of 8
STK_STEP, DATA_W/8, rsp increment/decrement for call/ret/push/pop
CNT_W, $clog2(DATA_W+1), multiply iteration counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous, active-low reset
E_stat  in  2  stat of the instruction in E (2'b01 AOK, 2'b10 HLT, 2'b11 ADR/INS, 2'b00 reserved)
E_icode  in  4  icode in E
E_ifun  in  4  ifun in E
E_valA, E_valB, E_valC  in  DATA_W  operands
E_dstE, E_dstM  in  4  destination registers (4'hF means none)
m_stat, W_stat  in  2  stats of the instructions currently in the M and W stages
M_stall  in  1  hold the M register
M_bubble  in  1  load a bubble into the M register
e_valE  out  DATA_W  combinational ALU result, for forwarding
e_dstE  out  4  combinational; E_dstE, or 4'hF when e_cnd=0
e_cnd  out  1  combinational condition result
e_busy  out  1  multiply in progress; upstream holds E and stalls
M_icode, M_stat, M_cnd, M_dstE, M_dstM, M_valE, M_valA  out  registered  M pipeline register

Behaviour:
- ALU operands and results by icode:
  - 2 rrmovq/cmovXX: valE=valA+0.
  - 3 irmovq: valC+0.
  - 4 rmmovq and 5 mrmovq: valB+valC.
  - 6 OPq: valB op valA; ifun 0 add, 1 sub (valB-valA), 2 and, 3 xor, 4 mul (low DATA_W bits of the two's-complement product).
  - 8 call and A push: valB-STK_STEP.
  - 9 ret and B pop: valB+STK_STEP.
  - Any other icode: valE=0.
- All arithmetic is modulo 2^DATA_W.
- Flags:
  - OF for add: operands have equal sign and the result sign differs.
  - OF for sub: operands have differing sign and the result sign differs from valB.
  - OF is 0 for and, xor and mul.
  - ZF = (result==0). SF = result[DATA_W-1].
- CC register {OF,SF,ZF}: reset value 3'b001 (ZF=1).
  - Written at a clock edge only when all hold: E_icode==6, E_ifun<=4, E_stat, m_stat and W_stat are all AOK, M_stall=0, and the FSM is not holding E (IDLE with a non-mul op, or DONE).
- e_cnd:
  - Evaluated from the CC register for icode 2 and 7.
  - ifun 0..6 are always, le, l, e, ne, ge, g.
  - ifun >6 gives 0.
  - For other icodes e_cnd=1.
- Multiply FSM states: IDLE, RUN, DONE.
  - IDLE, with E_icode=6, ifun=4, E_stat AOK: latch operands, clear accumulator and counter, go to RUN, e_busy=1.
  - RUN: one shift-add step per cycle. After DATA_W steps go to DONE. e_busy=1.
  - DONE: e_busy=0. e_valE = product. Return to IDLE at the edge where M captures (M_stall=0). If M_stall=1, stay in DONE.
  - Timing: mul presented at cycle t; e_busy high on cycles t..t+DATA_W; result on e_valE at cycle t+DATA_W+1.
  - A mul with non-AOK E_stat does not start; it passes through as a single-cycle op with valE=0.
- M register priority, per edge:
  1. !rst_n: reset values.
  2. M_bubble: bubble.
  3. M_stall: hold.
  4. e_busy=1: bubble.
  5. Otherwise capture: M_icode=E_icode, M_stat=E_stat, M_cnd=e_cnd, M_dstE=e_dstE, M_dstM=E_dstM, M_valE=e_valE, M_valA=E_valA.
- Bubble and reset values: M_icode=4'h1 (nop), M_stat=2'b01, M_cnd=0, M_dstE=M_dstM=4'hF, M_valE=M_valA=0.
- M_bubble does not disturb a running multiply.
- Reset mid-multiply: FSM to IDLE, e_busy=0, accumulator and counter cleared, CC=001.
- e_valE, e_dstE and e_cnd are purely combinational from E inputs, CC and FSM state. No latches are inferred.

Test Plan:
- DATA_W=64, addq valA=7 valB=5 -> e_valE=12; after the edge CC OF=0 SF=0 ZF=0; M_valE=12, M_icode=6.
- addq valA=1 valB=0x7FFF_FFFF_FFFF_FFFF -> e_valE=0x8000_0000_0000_0000, OF=1, SF=1, ZF=0. subq valA=valB=5 -> ZF=1.
- mulq valA=6 valB=-7 (0xFFFF_FFFF_FFFF_FFF9) -> e_busy high 65 cycles, M holds nop (M_icode=1) throughout; cycle 66 e_valE=0xFFFF_FFFF_FFFF_FFD6 (-42); CC SF=1 ZF=0 OF=0.
- Condition and stat gating:
  - CC=001: cmovle -> e_cnd=1, e_dstE=E_dstE.
  - cmovg -> e_cnd=0, e_dstE=F, M_dstE=F.
  - subq with m_stat=2'b10 -> CC unchanged.
- Stack ops: DATA_W=32 (STK_STEP=4), pushq valB=0x100 -> e_valE=0xFC; popq -> 0x104.
- Control priority:
  - M_stall=1 with M_bubble=0 -> M holds.
  - M_bubble=1 -> nop.
  - rst_n=0 at RUN cycle 20 -> next cycle e_busy=0, M = nop values, CC=001.
